// File: rtl/text_pkg.sv
// Shared constants and types for the text writer and the effect display blocks.
package text_pkg;

  localparam int unsigned NUM_DIGITS  = 7;
  localparam logic [2:0]  SLOT_LIMIT  = 3'(NUM_DIGITS);
  localparam logic [3:0]  CHECK_IDLE  = 4'd15;
  localparam logic [6:0]  BLANK_INDEX = 7'h7F;

  typedef logic [6:0] char_idx_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/text_writer_if.sv
// Message stream in, slot-select/index write port out, plus flush status.
interface text_writer_if;
  import text_pkg::*;

  logic       in_valid;
  logic       in_ready;
  char_idx_t  in_char;
  logic       in_last;
  logic [3:0] check;
  char_idx_t  text_index;
  logic       busy;
  logic       done;
  logic       ovf;

  modport slave (
    input  in_valid, in_char, in_last,
    output in_ready, check, text_index, busy, done, ovf
  );

  modport master (
    output in_valid, in_char, in_last,
    input  in_ready, check, text_index, busy, done, ovf
  );

endinterface

// File: rtl/text_buffer.sv
// NUM_DIGITS x 7 character buffer: one write port, one slot-addressed read
// port, synchronous clear to BLANK_INDEX.
module text_buffer
  import text_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [2:0] i_waddr,
  input  char_idx_t  i_wdata,
  input  logic [2:0] i_raddr,
  output char_idx_t  o_rdata
);

  char_idx_t r_mem [NUM_DIGITS];

  // Clear has priority over a write; out-of-range addresses are ignored.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_mem[i] <= BLANK_INDEX;
      end
    end else if (i_we && (i_waddr < SLOT_LIMIT)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Slot read; addresses past the last slot read as blank.
  always_comb begin
    o_rdata = BLANK_INDEX;
    if (i_raddr < SLOT_LIMIT) begin
      o_rdata = r_mem[i_raddr];
    end else begin
      o_rdata = BLANK_INDEX;
    end
  end

endmodule

// File: rtl/text_writer.sv
// Collects up to NUM_DIGITS character indices from a valid/ready stream and,
// on end-of-message, writes them one slot per cycle to the effect blocks.
// Build option: TEXT_WRITER_PAD_EN -- when defined every slot is written and
// unfilled slots get BLANK_INDEX; otherwise only the received slots are written.
module text_writer
  import text_pkg::*;
(
  input logic           clk,
  input logic           rst,
  text_writer_if.slave  bus
);

  state_t     r_state;
  logic [2:0] r_count;
  logic [2:0] r_slot;
  logic       r_ovf;
  logic       r_in_ready;
  logic [3:0] r_check;
  char_idx_t  r_text_index;
  logic       r_busy;
  logic       r_done;
  logic       r_ovf_out;

  logic       w_xfer;
  logic       w_store;
  logic       w_clr;
  logic [2:0] w_end;
  char_idx_t  w_rdata;
  char_idx_t  w_slot0;

  assign w_xfer  = (r_state == COLLECT) && bus.in_valid && r_in_ready;
  assign w_store = w_xfer && (r_count != SLOT_LIMIT);
  assign w_clr   = rst || (r_state == DONE);

`ifdef TEXT_WRITER_PAD_EN
  assign w_end = SLOT_LIMIT;
`else
  assign w_end = r_count;
`endif

  // The first slot goes out on the same edge as the last accept, so an
  // empty buffer must forward the incoming character directly.
  assign w_slot0 = (r_count == 3'd0) ? bus.in_char : w_rdata;

  text_buffer u_buffer (
    .i_clk   (clk),
    .i_clr   (w_clr),
    .i_we    (w_store),
    .i_waddr (r_count),
    .i_wdata (bus.in_char),
    .i_raddr (r_slot),
    .o_rdata (w_rdata)
  );

  // Collect/flush/done sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_count      <= 3'd0;
      r_slot       <= 3'd0;
      r_ovf        <= 1'b0;
      r_in_ready   <= 1'b0;
      r_check      <= CHECK_IDLE;
      r_text_index <= BLANK_INDEX;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf_out    <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_in_ready   <= 1'b1;
          r_check      <= CHECK_IDLE;
          r_text_index <= BLANK_INDEX;
          r_done       <= 1'b0;
          r_ovf_out    <= 1'b0;
          if (w_xfer) begin
            if (r_count != SLOT_LIMIT) begin
              r_count <= r_count + 3'd1;
            end else begin
              r_ovf <= 1'b1;
            end
            if (bus.in_last) begin
              r_state      <= FLUSH;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b1;
              r_check      <= 4'd0;
              r_text_index <= w_slot0;
              r_slot       <= 3'd1;
            end
          end
        end
        FLUSH: begin
          if (r_slot < w_end) begin
            r_check      <= {1'b0, r_slot};
            r_text_index <= w_rdata;
            r_slot       <= r_slot + 3'd1;
          end else begin
            r_check      <= CHECK_IDLE;
            r_text_index <= BLANK_INDEX;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_ovf_out    <= r_ovf;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_count    <= 3'd0;
          r_ovf      <= 1'b0;
          r_slot     <= 3'd0;
          r_done     <= 1'b0;
          r_ovf_out  <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= COLLECT;
        end
        default: begin
          r_state    <= COLLECT;
          r_count    <= 3'd0;
          r_slot     <= 3'd0;
          r_ovf      <= 1'b0;
          r_in_ready <= 1'b0;
          r_check    <= CHECK_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_ovf_out  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.check      = r_check;
  assign bus.text_index = r_text_index;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ovf        = r_ovf_out;

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer; expectations follow the
// TEXT_WRITER_PAD_EN build option.
module tb_text_writer;
  import text_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  text_writer_if bus ();

  text_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one character and hold it until accepted (bounded wait).
  task automatic send_char(input logic [6:0] c, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Called right after the last accept: expects m slot writes, then done.
  task automatic expect_flush(input int m, input logic [6:0] vals [7], input logic ovf_e);
    for (int i = 0; i < m; i++) begin
      check_val("slot_check", 32'(bus.check), 32'(i));
      check_val("slot_index", 32'(bus.text_index), 32'(vals[i]));
      check_val("flush_busy", 32'(bus.busy), 32'd1);
      check_val("flush_ready", 32'(bus.in_ready), 32'd0);
      check_val("flush_done", 32'(bus.done), 32'd0);
      step();
    end
    check_val("done_pulse", 32'(bus.done), 32'd1);
    check_val("done_ovf", 32'(bus.ovf), 32'(ovf_e));
    check_val("done_check", 32'(bus.check), 32'(CHECK_IDLE));
    check_val("done_busy", 32'(bus.busy), 32'd0);
    step();
    check_val("post_done", 32'(bus.done), 32'd0);
    check_val("post_ready", 32'(bus.in_ready), 32'd1);
  endtask

  logic [6:0] exp_vals [7];
  int         pad_m3;

  initial begin
    total = 0;
    bad = 0;
    bus.in_valid = 1'b0;
    bus.in_char  = 7'd0;
    bus.in_last  = 1'b0;
    rst = 1'b1;
`ifdef TEXT_WRITER_PAD_EN
    pad_m3 = 7;
`else
    pad_m3 = 3;
`endif
    step();
    step();
    check_val("rst_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
    check_val("rst_check", 32'(bus.check), 32'd15);
    check_val("rst_index", 32'(bus.text_index), 32'h7F);
    rst = 1'b0;

    // Full message 1..7.
    for (int i = 0; i < 7; i++) send_char(7'(i + 1), (i == 6));
    for (int i = 0; i < 7; i++) exp_vals[i] = 7'(i + 1);
    expect_flush(7, exp_vals, 1'b0);

    // Short message 10,11,12.
    send_char(7'd10, 1'b0);
    send_char(7'd11, 1'b0);
    send_char(7'd12, 1'b1);
    exp_vals = '{7'd10, 7'd11, 7'd12, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    expect_flush(pad_m3, exp_vals, 1'b0);

    // Overflow: 1..9, chars 8 and 9 dropped.
    for (int i = 0; i < 9; i++) send_char(7'(i + 1), (i == 8));
    for (int i = 0; i < 7; i++) exp_vals[i] = 7'(i + 1);
    expect_flush(7, exp_vals, 1'b1);

    // Character held on the stream throughout the flush.
    send_char(7'd20, 1'b0);
    send_char(7'd21, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_char  = 7'd30;
    bus.in_last  = 1'b1;
    exp_vals = '{7'd20, 7'd21, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`ifdef TEXT_WRITER_PAD_EN
    expect_flush(7, exp_vals, 1'b0);
`else
    expect_flush(2, exp_vals, 1'b0);
`endif
    send_char(7'd30, 1'b1);
    exp_vals = '{7'd30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`ifdef TEXT_WRITER_PAD_EN
    expect_flush(7, exp_vals, 1'b0);
`else
    expect_flush(1, exp_vals, 1'b0);
`endif

    // Reset in the third flush cycle aborts the flush.
    for (int i = 0; i < 5; i++) send_char(7'(i + 1), (i == 4));
    check_val("abort_c0", 32'(bus.check), 32'd0);
    step();
    check_val("abort_c1", 32'(bus.check), 32'd1);
    step();
    check_val("abort_c2", 32'(bus.check), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("abort_check", 32'(bus.check), 32'd15);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("abort_nodone", 32'(bus.done), 32'd0);
    end
    send_char(7'd40, 1'b0);
    send_char(7'd41, 1'b1);
    exp_vals = '{7'd40, 7'd41, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`ifdef TEXT_WRITER_PAD_EN
    expect_flush(7, exp_vals, 1'b0);
`else
    expect_flush(2, exp_vals, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_writer.md
# text_writer

Loader that feeds character indices into the seven-digit display effect blocks. It accepts a byte-serial message of character-table indices over a valid/ready stream and buffers up to seven characters. On end-of-message it writes each buffered character to its display slot using the effect blocks' slot-select/index write port (`check`/`text_index`). It sits between the message source (keypad/UART front end) and the `effect*` display modules.

## Interface
- `NUM_DIGITS`, 7: display slots; slot numbers are 0..NUM_DIGITS-1.
- `BLANK_INDEX`, 7'h7F: character index that renders all segments off.
- `CHECK_IDLE`, 4'd15: `check` value that selects no slot.
- `clk`  in  1: system clock. One clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_char` and `in_last` are valid.
- `in_ready`  out  1: block accepts a character this cycle.
- `in_char`  in  7: character-table index.
- `in_last`  in  1: final character of the message; qualified by `in_valid`.
- `check`  out  4: display slot being written; CHECK_IDLE when not writing.
- `text_index`  out  7: index written to slot `check`.
- `busy`  out  1: flush in progress.
- `done`  out  1: one-cycle pulse when the flush completes.
- `ovf`  out  1: valid with `done`; message exceeded NUM_DIGITS characters.

## Operation
- States: COLLECT, FLUSH, DONE. Reset state is COLLECT.
- COLLECT:
  - `in_ready`=1.
  - A transfer occurs when `in_valid & in_ready`.
  - If `count` < NUM_DIGITS: buf[count] <= `in_char`, then `count`++.
  - If `count` = NUM_DIGITS: the character is accepted and discarded, and the sticky `ovf_r` is set.
  - A transfer with `in_last`=1 stores or discards as above, then moves to FLUSH with `slot`=0.
- FLUSH:
  - `in_ready`=0, `busy`=1.
  - Each cycle drives `check`=`slot` and `text_index`=buf[`slot`], then `slot`++.
  - Leaves after the last slot, as set by the configuration below.
- DONE:
  - Lasts one cycle: `done`=1, `ovf`=`ovf_r`, `check`=CHECK_IDLE.
  - Clears `count`, `ovf_r`, and the buffer to BLANK_INDEX.
  - Returns to COLLECT.
- `count` is 3 bits and saturates at NUM_DIGITS; it never wraps.
- Characters arriving while the block is not in COLLECT are not accepted. The source must hold them, per the valid/ready rule.
- `in_valid` with `in_last`=0 on a cycle when `in_ready`=0 has no effect.

## Timing
- During `rst`:
  - `in_ready`=0, `busy`=0, `done`=0, `ovf`=0.
  - `check`=CHECK_IDLE, `text_index`=BLANK_INDEX.
  - `count`=0, buffer all BLANK_INDEX.
- `check` and `text_index` are registered.
- Timing for a last character accepted at edge T:
  - First slot write appears in the cycle after T.
  - One slot per cycle follows.
  - `done` appears in the cycle after the final write.
- Each slot is held for exactly one cycle; the effect blocks sample `check` every clock.
- Reset asserted mid-FLUSH aborts the flush. The next cycle shows `check`=CHECK_IDLE and no `done`. Slots already written keep their display values.
- Back-to-back messages: the first `in_ready`=1 occurs the cycle after `done`.

## Configuration
- `TEXT_WRITER_PAD_EN` defined:
  - FLUSH always writes all NUM_DIGITS slots; unfilled slots receive BLANK_INDEX.
  - Latency from last accept to `done` is NUM_DIGITS+1 cycles.
- `TEXT_WRITER_PAD_EN` undefined:
  - FLUSH writes only slots 0..`count`-1; other slots keep their previous display content.
  - Latency is `count`+1 cycles.

## Structure
- Shared package `text_pkg` holds:
  - NUM_DIGITS, CHECK_IDLE, BLANK_INDEX;
  - the state enum (COLLECT/FLUSH/DONE);
  - the 7-bit char-index typedef.
  - The `effect*` modules share these constants.
- One sub-module, `text_buffer`: an NUM_DIGITS x 7 register file with one write port, a slot-addressed read port, and a synchronous clear-to-BLANK_INDEX.

## Test plan
- Reset, then send 7 chars 1..7 with `in_last` on the 7th → `check`=0..6 with `text_index`=1..7 on consecutive cycles; then `done`=1, `ovf`=0 next cycle.
- 3 chars 10,11,12, last on 12, PAD_EN defined → slots 0..6 get 10,11,12,7F,7F,7F,7F; `done` 8 cycles after the last accept.
- Same stimulus, PAD_EN undefined → only `check`=0,1,2 driven; `done` 4 cycles after the last accept.
- 9 chars 1..9 → slots get 1..7, chars 8 and 9 dropped; `ovf`=1 with `done`.
- `in_valid` held high during FLUSH → `in_ready`=0, no buffer change; the held char is accepted the cycle after `done`.
- `rst` pulsed at the 3rd flush cycle → `check`=CHECK_IDLE next cycle, no `done`, `busy`=0; a new message is accepted normally after reset.
